rs_enc_param: RTL

RS_ENC_PARAM -- requirements
Module: rs_enc_param

---
 rtl/rs_enc_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rs_enc_param.sv
// Systematic RS encoder over GF(2^8): message passes through, then NSYM parity symbols, 1-cycle latency.
// Single output register; stalls (in_ready=0) while downstream holds off or parity is being emitted.
module rs_enc_param #(
    parameter int         NSYM      = 16,
    parameter logic [8:0] PRIM_POLY = 9'h11D,
    parameter int         FCR       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_parity,
    output logic       out_last
);
    localparam int CW = $clog2(NSYM) + 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ PRIM_POLY[7:0]) : (x << 1);
        end
        return p;
    endfunction

    // Low-order-first coefficients of prod (x + alpha^(FCR+i)); the monic top term is implicit.
    function automatic logic [NSYM*8-1:0] gen_poly();
        logic [7:0]        c [NSYM+1];
        logic [7:0]        root;
        logic [NSYM*8-1:0] res;
        for (int j = 0; j <= NSYM; j++) c[j] = 8'h00;
        c[0] = 8'h01;
        root = 8'h01;
        for (int k = 0; k < FCR; k++) root = gf_mul(root, 8'h02);
        for (int i = 0; i < NSYM; i++) begin
            for (int j = NSYM; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
            c[0] = gf_mul(c[0], root);
            root = gf_mul(root, 8'h02);
        end
        res = '0;
        for (int j = 0; j < NSYM; j++) res[j*8 +: 8] = c[j];
        return res;
    endfunction

    localparam logic [NSYM*8-1:0] G = gen_poly();

    typedef enum logic [1:0] {IDLE, MSG, PARITY} state_t;

    state_t          state_q;
    logic [7:0]      r_q   [NSYM];
    logic [7:0]      r_upd [NSYM];
    logic [7:0]      r_shf [NSYM];
    logic [CW-1:0]   cnt_q;
    logic            out_valid_q, out_parity_q, out_last_q;
    logic [7:0]      out_data_q;
    logic            load_ok, accept;
    logic [7:0]      fb;

    always_comb begin
        load_ok  = !out_valid_q || out_ready;
        in_ready = rst && load_ok && (state_q != PARITY);
        accept   = in_valid && in_ready;
        fb       = in_data ^ r_q[NSYM-1];
        r_upd[0] = gf_mul(G[7:0], fb);
        r_shf[0] = 8'h00;
        for (int i = 1; i < NSYM; i++) begin
            r_upd[i] = r_q[i-1] ^ gf_mul(G[i*8 +: 8], fb);
            r_shf[i] = r_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
            for (int i = 0; i < NSYM; i++) r_q[i] <= 8'h00;
        end else if (state_q == PARITY) begin
            if (load_ok) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= r_q[NSYM-1];
                out_parity_q <= 1'b1;
                out_last_q   <= (cnt_q == CW'(NSYM-1));
                r_q          <= r_shf;
                // Shifting NSYM times empties the LFSR, so the next codeword starts clean.
                if (cnt_q == CW'(NSYM-1)) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= in_data;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
            r_q          <= r_upd;
            state_q      <= in_last ? PARITY : MSG;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;
    assign out_last   = out_last_q;
endmodule
